// File: rtl/selftest_sequencer.sv
// Built-in self-test sequencer: streams LFSR vectors into the datapath, compacts
// the results into a MISR signature and reports pass/fail against a golden value.
module selftest_sequencer #(
  parameter int unsigned         DATA_W        = 16,
  parameter int unsigned         NUM_VECTORS   = 256,
  parameter logic [DATA_W-1:0]   LFSR_SEED     = DATA_W'(16'hACE1),
  parameter logic [DATA_W-1:0]   POLY          = DATA_W'(16'hB400),
  parameter logic [DATA_W-1:0]   GOLDEN_SIG    = DATA_W'(16'h0000),
  parameter int unsigned         DRAIN_TIMEOUT = 64,
  parameter int unsigned         LED_DIV_W     = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              dp_in_valid,
  input  logic              dp_in_ready,
  output logic [DATA_W-1:0] dp_in_data,
  input  logic              dp_out_valid,
  input  logic [DATA_W-1:0] dp_out_data,
  output logic              busy,
  output logic              gpio_out_pass,
  output logic              fail,
  output logic [DATA_W-1:0] signature,
  output logic              led
);

  localparam int unsigned CNT_W = $clog2(NUM_VECTORS + 1);
  localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN, ST_CHECK, ST_PASS, ST_FAIL
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     lfsr_q, lfsr_d;
  logic [DATA_W-1:0]     misr_q, misr_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic [CNT_W-1:0]      rcv_q, rcv_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  led_q, led_d;
  logic [LED_DIV_W-1:0]  div_q, div_d;
  logic                  xfer;
  logic                  accept;

  function automatic logic [DATA_W-1:0] galois_step(input logic [DATA_W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : '0);
  endfunction

  assign xfer   = valid_q & dp_in_ready;
  assign accept = dp_out_valid & ((state_q == ST_RUN) | (state_q == ST_DRAIN));

  // Next-state, datapath counters and registered-output decode
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    sent_d  = sent_q;
    rcv_d   = rcv_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;

    // Results past the expected count poison the run instead of wrapping the count
    if (accept) begin
      if (rcv_q == CNT_W'(NUM_VECTORS)) begin
        ovf_d = 1'b1;
      end else begin
        misr_d = galois_step(misr_q) ^ dp_out_data;
        rcv_d  = rcv_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        lfsr_d  = LFSR_SEED;
        misr_d  = '0;
        sent_d  = '0;
        rcv_d   = '0;
        timer_d = '0;
        ovf_d   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          lfsr_d = galois_step(lfsr_q);
          sent_d = sent_q + CNT_W'(1);
          if (sent_q == CNT_W'(NUM_VECTORS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        timer_d = accept ? '0 : timer_q + TMR_W'(1);
        if (rcv_q == CNT_W'(NUM_VECTORS)) begin
          state_d = ST_CHECK;
        end else if (timer_q == TMR_W'(DRAIN_TIMEOUT)) begin
          state_d = ST_FAIL;
        end
      end
      ST_CHECK: begin
        state_d = ((misr_q == GOLDEN_SIG) && !ovf_q) ? ST_PASS : ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_RUN);
    data_d  = valid_d ? lfsr_d : '0;
    busy_d  = state_d inside {ST_LOAD, ST_RUN, ST_DRAIN, ST_CHECK};
    pass_d  = (state_d == ST_PASS);
    fail_d  = (state_d == ST_FAIL);
    div_d   = div_q + LED_DIV_W'(1);

    case (state_d)
      ST_IDLE: led_d = 1'b0;
      ST_PASS: led_d = 1'b1;
      ST_FAIL: led_d = div_d[LED_DIV_W-4];
      default: led_d = div_d[LED_DIV_W-1];
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      sent_q  <= '0;
      rcv_q   <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      led_q   <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      sent_q  <= sent_d;
      rcv_q   <= rcv_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      led_q   <= led_d;
      div_q   <= div_d;
    end
  end

  assign dp_in_valid   = valid_q;
  assign dp_in_data    = data_q;
  assign busy          = busy_q;
  assign gpio_out_pass = pass_q;
  assign fail          = fail_q;
  assign signature     = misr_q;
  assign led           = led_q;

endmodule

// File: tb/tb_selftest_sequencer.sv
// Bench for selftest_sequencer: loopback datapath with optional corruption/drop,
// random backpressure, and a list-based model of vectors and signatures.
module tb_selftest_sequencer;

  localparam int          NV     = 4;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] POLY   = 16'hB400;
  localparam logic [15:0] GOLDEN = 16'h0000;
  localparam int          TMO    = 64;
  localparam int          PERIOD = 10;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic        dp_in_valid;
  logic        dp_in_ready;
  logic [15:0] dp_in_data;
  logic        dp_out_valid;
  logic [15:0] dp_out_data;
  logic        busy;
  logic        gpio_out_pass;
  logic        fail;
  logic [15:0] signature;
  logic        led;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_vec    [NV];
  logic [15:0] exp_prefix [NV];
  int          run_id = 0;
  int          ready_mode = 0;
  logic        cfg_corrupt = 1'b0;
  int          cfg_idx = 0;
  logic [15:0] cfg_mask = 16'h0;
  logic        cfg_drop = 1'b0;
  logic        dp_clear = 1'b0;
  int          dp_xfer;
  int          mon_xfers = 0;
  time         last_xfer_t = 0;

  selftest_sequencer #(
    .DATA_W(16), .NUM_VECTORS(NV), .LFSR_SEED(SEED), .POLY(POLY),
    .GOLDEN_SIG(GOLDEN), .DRAIN_TIMEOUT(TMO), .LED_DIV_W(24)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready), .dp_in_data(dp_in_data),
    .dp_out_valid(dp_out_valid), .dp_out_data(dp_out_data),
    .busy(busy), .gpio_out_pass(gpio_out_pass), .fail(fail),
    .signature(signature), .led(led)
  );

  always #(PERIOD/2) sys_clk = ~sys_clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0000);
  endfunction

  // Loopback datapath: one-cycle latency, optional single-word corruption or dropped last result
  always @(posedge sys_clk) begin
    if (!sys_rst_n || dp_clear) begin
      dp_out_valid <= 1'b0;
      dp_out_data  <= 16'h0;
      dp_xfer      <= 0;
    end else begin
      dp_out_valid <= 1'b0;
      if (dp_in_valid && dp_in_ready) begin
        dp_xfer <= dp_xfer + 1;
        if (!(cfg_drop && dp_xfer == NV - 1)) begin
          dp_out_valid <= 1'b1;
          dp_out_data  <= dp_in_data ^ ((cfg_corrupt && dp_xfer == cfg_idx) ? cfg_mask : 16'h0);
        end
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  initial begin
    int pat = 0;
    dp_in_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0: dp_in_ready = 1'b1;
        1: dp_in_ready = ($urandom_range(0, 2) != 0);
        default: begin
          dp_in_ready = (pat == 0 || pat == 3);
          pat = (pat + 1) % 4;
        end
      endcase
    end
  end

  // Monitor: vector order, stall stability and MISR value after every result
  initial begin
    int          seen = -1;
    int          res_k = 0;
    logic        pend = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] held = 16'h0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        pend  = 1'b0;
        stall = 1'b0;
        continue;
      end
      if (run_id != seen) begin
        seen = run_id; mon_xfers = 0; res_k = 0; pend = 1'b0; stall = 1'b0;
      end
      if (pend) begin
        if (res_k < NV) chk_eq("misr_step", 32'(signature), 32'(exp_prefix[res_k]));
        res_k++;
      end
      pend = dp_out_valid;
      if (stall && dp_in_valid) chk_eq("stall_hold", 32'(dp_in_data), 32'(held));
      if (dp_in_valid && dp_in_ready) begin
        if (mon_xfers < NV) chk_eq("vector", 32'(dp_in_data), 32'(exp_vec[mon_xfers]));
        else chk_eq("xfer_over", 32'(mon_xfers + 1), 32'(NV));
        mon_xfers++;
        last_xfer_t = $time;
      end
      stall = dp_in_valid && !dp_in_ready;
      held  = dp_in_data;
    end
  end

  // Model: vector list from the LFSR rule, signature folded over delivered results
  task automatic prep(input int rmode, input logic corr, input int cidx,
                      input logic [15:0] cmask, input logic drop,
                      output logic [15:0] sig, output logic pass_exp);
    ready_mode  = rmode;
    cfg_corrupt = corr;
    cfg_idx     = cidx;
    cfg_mask    = cmask;
    cfg_drop    = drop;
    exp_vec[0]  = SEED;
    for (int i = 1; i < NV; i++) exp_vec[i] = galois(exp_vec[i-1]);
    sig = 16'h0;
    for (int i = 0; i < NV; i++) begin
      exp_prefix[i] = 16'h0;
      if (!(drop && i == NV - 1)) begin
        sig = galois(sig) ^ (exp_vec[i] ^ ((corr && i == cidx) ? cmask : 16'h0));
        exp_prefix[i] = sig;
      end
    end
    pass_exp = !drop && (sig == GOLDEN);
  endtask

  task automatic kick();
    @(negedge sys_clk);
    dp_clear = 1'b1;
    run_id++;
    @(negedge sys_clk);
    dp_clear = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    chk_eq("sig_cleared", 32'(signature), 32'h0);
    chk_eq("busy_run", 32'(busy), 32'h1);
  endtask

  task automatic do_run(input int rmode, input logic corr, input int cidx,
                        input logic [15:0] cmask, input logic drop, input logic busy_start);
    logic [15:0] sig;
    logic        pass_exp;
    logic        done;
    int          lat;
    prep(rmode, corr, cidx, cmask, drop, sig, pass_exp);
    kick();
    if (busy_start) begin
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
    end
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge sys_clk);
      if (gpio_out_pass || fail) done = 1'b1;
    end
    chk_eq("outcome_seen", 32'(done), 32'h1);
    // Final transfer -> result -> count -> CHECK -> registered outcome = 4 cycles;
    // a missing result instead waits out 64 idle DRAIN cycles plus decision and register.
    lat = int'(($time - last_xfer_t) / PERIOD);
    chk_eq("pass", 32'(gpio_out_pass), 32'(pass_exp));
    chk_eq("fail", 32'(fail), 32'(!pass_exp));
    chk_eq("signature", 32'(signature), 32'(sig));
    chk_eq("xfers", 32'(mon_xfers), 32'(NV));
    chk_eq("latency", 32'(lat), drop ? 32'(TMO + 2) : 32'd4);
    chk_eq("busy_done", 32'(busy), 32'h0);
    chk_eq("valid_done", 32'(dp_in_valid), 32'h0);
    if (pass_exp) chk_eq("led_pass", 32'(led), 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_valid"}, 32'(dp_in_valid), 32'h0);
    chk_eq({tag, "_data"}, 32'(dp_in_data), 32'h0);
    chk_eq({tag, "_busy"}, 32'(busy), 32'h0);
    chk_eq({tag, "_pass"}, 32'(gpio_out_pass), 32'h0);
    chk_eq({tag, "_fail"}, 32'(fail), 32'h0);
    chk_eq({tag, "_sig"}, 32'(signature), 32'h0);
    chk_eq({tag, "_led"}, 32'(led), 32'h0);
  endtask

  task automatic mid_reset();
    logic [15:0] sig;
    logic        pass_exp;
    logic        hit;
    prep(0, 1'b0, 0, 16'h0, 1'b0, sig, pass_exp);
    kick();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge sys_clk);
      #1;
      if (mon_xfers >= 2) hit = 1'b1;
    end
    chk_eq("two_xfers_seen", 32'(hit), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk_eq("idle_busy", 32'(busy), 32'h0);
    chk_eq("idle_led", 32'(led), 32'h0);

    do_run(0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    do_run(0, 1'b1, 2, 16'h0001, 1'b0, 1'b0);
    do_run(2, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    do_run(0, 1'b0, 0, 16'h0, 1'b1, 1'b0);
    mid_reset();
    do_run(0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    do_run(2, 1'b0, 0, 16'h0, 1'b0, 1'b1);
    do_run(0, 1'b0, 0, 16'h0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      do_run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, NV - 1)), 16'($urandom_range(1, 16'hFFFF)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
